// File: rtl/prbs8_checker.sv
// PRBS8 stream checker: hunts for a seed, verifies LOCK_COUNT consecutive predictions,
// then free-runs its prediction while locked and counts mismatching words.
module prbs8_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam logic [1:0] HUNT     = 2'd0;
  localparam logic [1:0] VERIFY   = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [3:0]       LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [3:0]       LOSS_CNT = 4'(LOSS_COUNT);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  // Generator polynomial x^8 + x^6 + 1, shifting toward the MSB.
  function automatic logic [7:0] prbs_next(input logic [7:0] w);
    return {w[6:0], w[7] ^ w[5]};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [7:0]       expected_q, expected_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d     = state_q;
    expected_d  = expected_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_data != 8'h00) begin
            expected_d = prbs_next(in_data);
            match_d    = '0;
            state_d    = VERIFY;
          end
        end
        VERIFY: begin
          if (in_data == expected_q) begin
            match_d    = match_q + 4'd1;
            expected_d = prbs_next(in_data);
            if (match_d == LOCK_CNT) begin
              state_d = S_LOCKED;
              miss_d  = '0;
            end
          end else if (in_data == 8'h00) begin
            state_d = HUNT;
          end else begin
            expected_d = prbs_next(in_data);
            match_d    = '0;
          end
        end
        S_LOCKED: begin
          // Prediction free-runs so a corrupted word never becomes the next seed.
          expected_d = prbs_next(expected_q);
          if (in_data == expected_q) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != ERR_MAX) err_count_d = err_count_q + ERR_ONE;
            miss_d = miss_q + 4'd1;
            if (miss_d == LOSS_CNT) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (err_clr) err_count_d = '0;
  end

  assign locked_d = (state_d == S_LOCKED);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      expected_q  <= 8'h00;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign state     = state_q;
  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// Self-checking bench for prbs8_checker: directed acquisition/error/loss scenarios
// followed by a randomized PRBS stream, compared against a behavioural model.
module tb_prbs8_checker;

  localparam int LOCK_COUNT = 4;
  localparam int LOSS_COUNT = 3;
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        err_clr;
  logic        locked, locked2;
  logic        err_pulse, err_pulse2;
  logic [15:0] err_count;
  logic [1:0]  err_count2;
  logic [1:0]  state, state2;

  always #5 clk = ~clk;

  prbs8_checker dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .err_clr(err_clr),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state(state)
  );

  prbs8_checker #(.ERR_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .err_clr(err_clr),
    .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2), .state(state2)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural reference: what the checker believes about the stream.
  int         m_state;
  logic [7:0] m_exp;
  int         m_hits, m_misses;
  int         m_err, m_err2;
  bit         m_pulse;

  function automatic logic [7:0] nxt(input logic [7:0] w);
    logic [7:0] r;
    r = (w << 1) & 8'hFE;
    r[0] = w[7] ^ w[5];
    return r;
  endfunction

  task automatic model_reset();
    m_state = M_HUNT; m_exp = 8'h00; m_hits = 0; m_misses = 0;
    m_err = 0; m_err2 = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit clr);
    bit hit;
    m_pulse = 0;
    if (v) begin
      hit = (d == m_exp);
      if (m_state == M_LOCKED) begin
        m_exp = nxt(m_exp);
        if (hit) m_misses = 0;
        else begin
          m_pulse = 1;
          m_err  = (m_err  < 65535) ? m_err + 1  : m_err;
          m_err2 = (m_err2 < 3)     ? m_err2 + 1 : m_err2;
          m_misses++;
          if (m_misses == LOSS_COUNT) m_state = M_HUNT;
        end
      end else if (m_state == M_VERIFY && hit) begin
        m_hits++;
        m_exp = nxt(d);
        if (m_hits == LOCK_COUNT) begin m_state = M_LOCKED; m_misses = 0; end
      end else if (d == 8'h00) begin
        m_state = M_HUNT;
      end else begin
        m_exp = nxt(d); m_hits = 0; m_state = M_VERIFY;
      end
    end
    if (clr) begin m_err = 0; m_err2 = 0; end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".state"},      32'(state),      32'(m_state));
    check_val({tag, ".locked"},     32'(locked),     32'(m_state == M_LOCKED));
    check_val({tag, ".err_pulse"},  32'(err_pulse),  32'(m_pulse));
    check_val({tag, ".err_count"},  32'(err_count),  32'(m_err));
    check_val({tag, ".err_count2"}, 32'(err_count2), 32'(m_err2));
  endtask

  task automatic step(input string tag, input bit v, input logic [7:0] d, input bit clr);
    @(negedge clk);
    in_valid = v; in_data = d; err_clr = clr;
    @(posedge clk);
    model_step(v, d, clr);
    #1;
    check_all(tag);
  endtask

  logic [7:0] g;
  logic [7:0] words[$];

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; err_clr = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Lockup word keeps the checker hunting.
    step("zero_hunt", 1, 8'h00, 0);
    step("zero_hunt", 1, 8'h00, 0);
    check_val("zero_hunt_state", 32'(state), 0);

    // Acquisition and polynomial continuation.
    words = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    foreach (words[i]) begin
      step("acquire", 1, words[i], 0);
      if (i == 0) check_val("acq_verify", 32'(state), 1);
    end
    check_val("acq_locked", 32'(locked), 1);
    words = '{8'h20, 8'h41, 8'h82, 8'h05};
    foreach (words[i]) step("poly", 1, words[i], 0);
    check_val("poly_locked", 32'(locked), 1);
    check_val("poly_errs", 32'(err_count), 0);

    // Three consecutive wrong words lose lock; every one is counted.
    g = nxt(8'h05);
    for (int i = 0; i < 3; i++) begin
      step("loss", 1, ~g, 0);
      g = nxt(g);
    end
    check_val("loss_state", 32'(state), 0);
    check_val("loss_errs", 32'(err_count), 3);

    // Re-lock after 1+LOCK_COUNT words, then single corrupted word.
    words = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h82, 8'h05};
    foreach (words[i]) begin
      step("single_err", 1, words[i], 0);
      if (i == 4) check_val("relock", 32'(locked), 1);
      if (i == 6) check_val("single_pulse", 32'(err_pulse), 1);
    end
    check_val("single_count", 32'(err_count), 4);
    check_val("single_still_locked", 32'(locked), 1);

    // Gaps: prediction must hold still while in_valid is low.
    g = nxt(8'h05);
    for (int i = 0; i < 6; i++) begin
      step("gap_idle", 0, $urandom_range(0, 255), 0);
      step("gap_word", 1, g, 0);
      g = nxt(g);
    end
    check_val("gap_errs", 32'(err_count), 4);

    // Five isolated errors; the 2-bit counter sticks at 3.
    step("clr", 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) begin
      step("sat_err", 1, ~g, 0);
      g = nxt(g);
      step("sat_ok", 1, g, 0);
      g = nxt(g);
    end
    check_val("sat_count2", 32'(err_count2), 3);
    check_val("sat_count", 32'(err_count), 5);

    // Clear wins over a simultaneous error.
    step("clr_vs_err", 1, ~g, 1);
    g = nxt(g);
    check_val("clr_win", 32'(err_count), 0);

    // Randomized stream with corruption, zeros, gaps and clears.
    for (int i = 0; i < 400; i++) begin
      int r;
      bit v;
      logic [7:0] d;
      r = $urandom_range(0, 99);
      v = ($urandom_range(0, 99) < 80);
      d = g;
      if (r < 8) d = 8'($urandom_range(0, 255));
      else if (r < 11) d = 8'h00;
      step("random", v, d, ($urandom_range(0, 99) < 3));
      if (v) g = nxt(g);
    end

    // Lock up again, then reset mid-stream.
    step("pre_rst", 1, 8'h01, 0);
    g = 8'h02;
    for (int i = 0; i < 5; i++) begin
      step("pre_rst", 1, g, 0);
      g = nxt(g);
    end
    step("pre_rst_err", 1, ~g, 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    check_val("async_rst_locked", 32'(locked), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step("post_rst", 1, 8'h33, 0);
    check_val("post_rst_verify", 32'(state), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prbs8_checker.md
PRBS8_CHECKER -- requirements
Module: prbs8_checker

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4, meaning consecutive matching words needed to declare lock (range 1-15).
REQ-002 SHALL have parameter LOSS_COUNT, default 3, meaning consecutive mismatching words while locked that force loss of lock (range 1-15).
REQ-003 SHALL have parameter ERR_W, default 16, meaning width of the error counter.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data carries a sample this cycle.
REQ-007 SHALL have port in_data, input, 8 bits: one full 8-bit word from the PRBS8 generator per valid cycle.
REQ-008 SHALL have port err_clr, input, 1 bit: synchronous clear of err_count.
REQ-009 SHALL have port locked, output, 1 bit: checker is synchronised to the stream.
REQ-010 SHALL have port err_pulse, output, 1 bit: one-cycle flag for a mismatching word while locked.
REQ-011 SHALL have port err_count, output, ERR_W bits: saturating count of mismatching words while locked.
REQ-012 SHALL have port state, output, 2 bits: HUNT=0, VERIFY=1, LOCKED=2.

Function
REQ-013 SHALL define next(w) = {w[6:0], w[7]^w[5]}, matching the team's 8-bit generator polynomial (taps 8 and 6, shift toward MSB, feedback into bit 0).
REQ-014 SHALL hold an internal 8-bit register expected, a 4-bit match counter and a 4-bit miss counter.
REQ-015 SHALL leave all state, counters and expected unchanged in any cycle with in_valid=0.
REQ-016 HUNT: on a valid word w != 0x00, SHALL set expected=next(w), clear the match counter and go to VERIFY. A word of 0x00 is the lockup value and SHALL leave the block in HUNT.
REQ-017 VERIFY, valid word w == expected: SHALL increment the match counter and set expected=next(w). When the counter reaches LOCK_COUNT, SHALL go to LOCKED and clear the miss counter.
REQ-018 VERIFY, valid word w != expected: SHALL re-seed as in REQ-016 and stay in VERIFY, or go to HUNT if w == 0x00. This case SHALL NOT count as an error.
REQ-019 LOCKED: SHALL always advance expected=next(expected), free-running, so a corrupted word does not corrupt the prediction.
REQ-020 LOCKED, valid word w == expected: SHALL clear the miss counter.
REQ-021 LOCKED, valid word w != expected: SHALL assert err_pulse on the next cycle, increment err_count and increment the miss counter.
REQ-022 LOCKED, miss counter reaching LOSS_COUNT: SHALL go to HUNT. That final mismatching word SHALL still be counted and SHALL NOT be used as a seed.
REQ-023 All outputs SHALL be registered. locked SHALL be high exactly when state==LOCKED.
REQ-024 err_count SHALL saturate at all-ones and never wrap.
REQ-025 err_clr and an error in the same cycle: clear SHALL win and err_count SHALL become 0.
REQ-026 err_pulse SHALL be high for exactly one cycle per mismatching locked word. It SHALL be low in all other cycles.

Reset
REQ-027 reset_n=0 SHALL asynchronously force state=HUNT, locked=0, err_pulse=0, err_count=0, expected=0x00, match counter=0 and miss counter=0.
REQ-028 Reset asserted mid-operation SHALL discard lock and counts immediately. After release, the block SHALL re-acquire from HUNT on the next valid word.
REQ-029 Release of reset SHALL take effect synchronously, on the first clk edge after reset_n rises.

Verification
REQ-030 Acquire: after reset, drive valid words 0x01,0x02,0x04,0x08,0x10 on consecutive cycles -> state goes HUNT, VERIFY, then locked=1 after the edge sampling 0x10; err_count=0.
REQ-031 Polynomial: continue the stream 0x20,0x41,0x82,0x05 -> locked stays 1 and err_pulse stays 0 (checks the bit7^bit5 feedback).
REQ-032 Single error: while locked, replace one expected 0x41 with 0x40 -> err_pulse=1 for one cycle, err_count=1, locked stays 1, and the next correct word 0x82 matches.
REQ-033 Loss of lock: while locked, drive 3 consecutive wrong words -> err_count +3, state=HUNT, locked=0. Then a clean stream re-locks after 1+LOCK_COUNT words.
REQ-034 Gaps and zero: 0x00 words in HUNT -> stays HUNT. A locked stream with in_valid=0 gaps inserted -> no errors, and expected does not advance during gaps.
REQ-035 Counter edges: with ERR_W=2, drive 5 errors -> err_count stays 3. Assert err_clr together with an error -> err_count=0. Assert reset_n low mid-stream -> all outputs return to reset values immediately.
